// File: rtl/rotation_line_parser.sv
// Converts an ASCII stream of "L<n>\n" / "R<n>\n" lines into rotation commands
// for the dial stage, with a valid/ready output and issued/rejected counters.
module rotation_line_parser #(
    parameter int DIS_W = 10,
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_dirn,
    output logic [DIS_W-1:0] cmd_dis,
    output logic             cmd_sat,
    output logic [CNT_W-1:0] cmd_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {IDLE, DIGITS, SKIP, EMIT} state_t;

    localparam logic [DIS_W-1:0] DIS_MAX = '1;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    state_t             state, state_n;
    logic               dirn_q, dirn_n;
    logic [DIS_W-1:0]   acc_q, acc_n;
    logic               sat_q, sat_n;
    logic               seen_q, seen_n;
    logic               err_inc;
    logic               in_fire, cmd_fire, is_digit;
    logic [DIS_W+3:0]   prod;

    assign in_ready  = !rst && (state != EMIT);
    assign cmd_valid = (state == EMIT);
    assign cmd_dirn  = dirn_q;
    assign cmd_dis   = acc_q;
    assign cmd_sat   = sat_q;

    assign in_fire  = in_valid & in_ready;
    assign cmd_fire = cmd_valid & cmd_ready;
    assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);
    // ASCII '0'..'9' carry their value in the low nibble; 4 extra bits hold acc*10+9
    assign prod = {4'b0000, acc_q} * (DIS_W+4)'(10) + {{DIS_W{1'b0}}, in_data[3:0]};

    always_comb begin
        state_n = state;
        dirn_n  = dirn_q;
        acc_n   = acc_q;
        sat_n   = sat_q;
        seen_n  = seen_q;
        err_inc = 1'b0;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    if (in_data == CH_L || in_data == CH_R) begin
                        dirn_n  = (in_data == CH_R);
                        acc_n   = '0;
                        sat_n   = 1'b0;
                        seen_n  = 1'b0;
                        state_n = DIGITS;
                    end else if (in_data != CH_NL && in_data != CH_CR && in_data != CH_SP) begin
                        err_inc = 1'b1;
                        state_n = SKIP;
                    end
                end
            end
            DIGITS: begin
                if (in_fire) begin
                    if (is_digit) begin
                        seen_n = 1'b1;
                        if (sat_q || prod > {4'b0000, DIS_MAX}) begin
                            acc_n = DIS_MAX;
                            sat_n = 1'b1;
                        end else begin
                            acc_n = prod[DIS_W-1:0];
                        end
                    end else if (in_data == CH_NL) begin
                        if (seen_q) begin
                            state_n = EMIT;
                        end else begin
                            err_inc = 1'b1;
                            state_n = IDLE;
                        end
                    end else if (in_data != CH_CR) begin
                        err_inc = 1'b1;
                        state_n = SKIP;
                    end
                end
            end
            SKIP: begin
                if (in_fire && in_data == CH_NL) state_n = IDLE;
            end
            EMIT: begin
                if (cmd_fire) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dirn_q    <= 1'b0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            seen_q    <= 1'b0;
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            state  <= state_n;
            dirn_q <= dirn_n;
            acc_q  <= acc_n;
            sat_q  <= sat_n;
            seen_q <= seen_n;
            if (cmd_fire) cmd_count <= cmd_count + 1'b1;
            if (err_inc && err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rotation_line_parser.sv
// Self-checking bench for rotation_line_parser: line table, scoreboard queue,
// hand-written backpressure/reset sequences and a randomised handshake run.
module tb_rotation_line_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dirn;
    logic [9:0]  cmd_dis;
    logic        cmd_sat;
    logic [31:0] cmd_count;
    logic [15:0] err_count;

    rotation_line_parser #(.DIS_W(10), .CNT_W(32), .ERR_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dirn(cmd_dirn), .cmd_dis(cmd_dis), .cmd_sat(cmd_sat),
        .cmd_count(cmd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dirn;
        logic [9:0] dis;
        logic       sat;
    } cmd_t;

    typedef struct {
        string txt;
        bit    emits;
        bit    dirn;
        int    dis;
        bit    sat;
        int    errs;
    } vec_t;

    cmd_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   expErr = 0;
    int   expCmd = 0;
    int   readyMode = 0;
    vec_t vecs[13];

    always @(posedge clk) begin
        #1;
        if (readyMode == 0) cmd_ready = 1'b1;
        else if (readyMode == 1) cmd_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: a transfer happens at the next rising edge whenever both sides are high here
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_cmd got dirn=%0d dis=%0d sat=%0d, none expected",
                         cmd_dirn, cmd_dis, cmd_sat);
            end else begin
                cmd_t e;
                e = expQ.pop_front();
                if ({cmd_dirn, cmd_dis, cmd_sat} != e) begin
                    errors++;
                    $display("[TB] FAIL cmd got dirn=%0d dis=%0d sat=%0d expected dirn=%0d dis=%0d sat=%0d",
                             cmd_dirn, cmd_dis, cmd_sat, e.dirn, e.dis, e.sat);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {19'd0, in_ready, cmd_valid, cmd_dirn, cmd_dis, cmd_sat}, 32'd0);
        checkOutput({name, "_cnt"}, cmd_count | {16'd0, err_count}, 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
        expErr = 0;
        expCmd = 0;
    endtask

    // Called and returns 1 time unit after a rising edge
    task automatic sendByte(input byte b, input bit randGap);
        int  guard = 0;
        bit  took;
        if (randGap) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            if (took) break;
            guard++;
            if (guard > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL in_ready_timeout byte=%0h", b);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input bit randGap);
        if (v.emits) begin
            expQ.push_back('{dirn: v.dirn, dis: 10'(v.dis), sat: v.sat});
            expCmd++;
        end
        expErr += v.errs;
        for (int i = 0; i < v.txt.len(); i++) sendByte(v.txt[i], randGap);
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (expQ.size() != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_drain got %0d pending expected 0", name, expQ.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vecs[0]  = '{"L68\n",         1'b1, 1'b0, 68,   1'b0, 0};
        vecs[1]  = '{"R48\n",         1'b1, 1'b1, 48,   1'b0, 0};
        vecs[2]  = '{"R1023\n",       1'b1, 1'b1, 1023, 1'b0, 0};
        vecs[3]  = '{"L1024\n",       1'b1, 1'b0, 1023, 1'b1, 0};
        vecs[4]  = '{"R99999\n",      1'b1, 1'b1, 1023, 1'b1, 0};
        vecs[5]  = '{"X12\n",         1'b0, 1'b0, 0,    1'b0, 1};
        vecs[6]  = '{"L\n",           1'b0, 1'b0, 0,    1'b0, 1};
        vecs[7]  = '{"R5a\n",         1'b0, 1'b0, 0,    1'b0, 1};
        vecs[8]  = '{"L7\015\n",      1'b1, 1'b0, 7,    1'b0, 0};
        vecs[9]  = '{"R007\n",        1'b1, 1'b1, 7,    1'b0, 0};
        vecs[10] = '{"L0\n",          1'b1, 1'b0, 0,    1'b0, 0};
        vecs[11] = '{"R3 \n",         1'b0, 1'b0, 0,    1'b0, 1};
        vecs[12] = '{"\015\n L2\n",   1'b1, 1'b0, 2,    1'b0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        cmd_ready = 1'b0;
        #2 checkAllZero("reset_outputs");
        doReset();

        readyMode = 0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i], 1'b0);
            if (i == 1) begin
                drain("lines12");
                checkOutput("cmd_count_after_2", cmd_count, 32'd2);
                checkOutput("err_count_after_2", {16'd0, err_count}, 32'd0);
            end
        end
        drain("table");
        checkOutput("cmd_count_table", cmd_count, 32'(expCmd));
        checkOutput("err_count_table", {16'd0, err_count}, 32'(expErr));

        // Backpressure: command must hold while cmd_ready stays low
        doReset();
        readyMode = 2;
        cmd_ready = 1'b0;
        applyStimulus('{"R5\n", 1'b1, 1'b1, 5, 1'b0, 0}, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_cycle", {cmd_valid, in_ready, cmd_dirn, cmd_dis, cmd_count[19:0]},
                        {1'b1, 1'b0, 1'b1, 10'd5, 20'd0});
        end
        @(posedge clk); #1 cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_count", cmd_count, 32'd1);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
        readyMode = 0;
        drain("backpressure");

        // Asynchronous reset mid-line drops the partial command
        doReset();
        sendByte("L", 1'b0);
        sendByte("1", 1'b0);
        sendByte("2", 1'b0);
        #2 rst = 1'b1;
        #1 checkAllZero("async_reset");
        @(posedge clk); #1;
        checkAllZero("async_reset_held");
        rst = 1'b0;
        expQ.delete();
        expErr = 0;
        expCmd = 0;
        applyStimulus('{"R3\n", 1'b1, 1'b1, 3, 1'b0, 0}, 1'b0);
        drain("after_reset");
        checkOutput("cmd_count_after_reset", cmd_count, 32'd1);
        checkOutput("err_count_after_reset", {16'd0, err_count}, 32'd0);

        // Random handshakes on both sides against an unbounded-arithmetic model
        doReset();
        readyMode = 1;
        for (int n = 0; n < 40; n++) begin
            int     nd;
            longint val;
            byte    digs[5];
            bit     d;
            cmd_t   e;
            nd  = $urandom_range(1, 5);
            d   = 1'($urandom_range(0, 1));
            val = 0;
            for (int k = 0; k < nd; k++) begin
                int dv;
                dv = $urandom_range(0, 9);
                digs[k] = byte'(8'h30 + dv);
                val = val * 10 + dv;
            end
            e.dirn = d;
            e.sat  = (val > 1023);
            e.dis  = e.sat ? 10'd1023 : 10'(val);
            expQ.push_back(e);
            expCmd++;
            sendByte(d ? "R" : "L", 1'b1);
            for (int k = 0; k < nd; k++) sendByte(digs[k], 1'b1);
            sendByte(8'h0A, 1'b1);
        end
        drain("random");
        checkOutput("cmd_count_random", cmd_count, 32'(expCmd));
        checkOutput("err_count_random", {16'd0, err_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
